// File: rtl/negedge_and_or_reg_pkg.sv
// Shared constants for the negedge_and_or_reg block.
package negedge_and_or_reg_pkg;

  // Value forced onto B while rst_n is low.
  localparam logic B_RST = 1'b0;

endpackage : negedge_and_or_reg_pkg

// File: rtl/negedge_and_or_reg_and_or_next.sv
// Next-state logic for negedge_and_or_reg.
// c2 is checked first and wins over c1; when neither holds, B keeps its value.
module and_or_next #(
  parameter int unsigned W = 2
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  input  logic         A,
  input  logic         B,
  output logic         B_d
);

  logic xa, ya, za;
  logic c1, c2;
  logic v1, v2;

  // Reduce the operand buses, then select AND/OR candidate or hold.
  always_comb begin
    xa  = |x;
    ya  = |y;
    za  = |z;
    c1  = xa | (ya & za);
    c2  = xa | (ya & ~za);
    v1  = A & z[0];
    v2  = A | x[0];
    B_d = B;
    if (c2) begin
      B_d = v2;
    end else if (c1) begin
      B_d = v1;
    end
  end

endmodule : and_or_next

// File: rtl/negedge_and_or_reg.sv
// Single-bit registered AND/OR selector, updated on the falling clock edge.
module negedge_and_or_reg
  import negedge_and_or_reg_pkg::*;
#(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  input  logic         A,
  output logic         B
);

  logic B_q;
  logic B_d;

  and_or_next #(
    .W (W)
  ) u_next (
    .x   (x),
    .y   (y),
    .z   (z),
    .A   (A),
    .B   (B_q),
    .B_d (B_d)
  );

  // Falling-edge result register with asynchronous active-low clear.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      B_q <= B_RST;
    end else begin
      B_q <= B_d;
    end
  end

  assign B = B_q;

endmodule : negedge_and_or_reg

// File: tb/tb_negedge_and_or_reg.sv
// Self-checking bench for negedge_and_or_reg: directed cases, a full input
// sweep and randomized traffic against a truth-table reference model.
module tb_negedge_and_or_reg;

  localparam int unsigned W = 2;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] x, y, z;
  logic         A;
  logic         B;

  int unsigned  total;
  int unsigned  passed;
  logic         exp_b;

  negedge_and_or_reg #(
    .W (W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .x     (x),
    .y     (y),
    .z     (z),
    .A     (A),
    .B     (B)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  // Reference: the truth summary of the block, written case by case.
  function automatic logic model_next(input logic [W-1:0] xv, input logic [W-1:0] yv,
                                      input logic [W-1:0] zv, input logic av,
                                      input logic cur);
    if (xv != '0) return av | xv[0];
    if (yv == '0) return cur;
    if (zv != '0) return av & zv[0];
    return av;
  endfunction

  task automatic check(input string tag, input logic obs, input logic expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %b expected %b at %0t", tag, obs, expv, $time);
  endtask

  // Drive a vector between edges, confirm the rising edge changes nothing,
  // then check B one step after the falling edge.
  task automatic step(input logic [W-1:0] xv, input logic [W-1:0] yv,
                      input logic [W-1:0] zv, input logic av, input string tag);
    @(posedge clk);
    #1;
    check({tag, "_posedge_hold"}, B, exp_b);
    x = xv; y = yv; z = zv; A = av;
    @(negedge clk);
    #1;
    if (!rst_n) exp_b = 1'b0;
    else        exp_b = model_next(xv, yv, zv, av, exp_b);
    check(tag, B, exp_b);
  endtask

  // Pulse reset mid-cycle and confirm B clears immediately.
  task automatic mid_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    exp_b = 1'b0;
    check(tag, B, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    rst_n  = 1'b0;
    x = '0; y = '0; z = '0; A = 1'b0;
    exp_b  = 1'b0;
    #2;
    check("reset_value", B, 1'b0);
    #1;
    rst_n = 1'b1;

    // OR path dominates whenever x is nonzero.
    step(2'b01, 2'b00, 2'b11, 1'b0, "xdom_lsb");
    check("xdom_lsb_const", B, 1'b1);
    step(2'b10, 2'b00, 2'b11, 1'b0, "xdom_msb");
    check("xdom_msb_const", B, 1'b0);

    // AND path uses only z[0].
    step(2'b00, 2'b10, 2'b01, 1'b1, "and_z0");
    check("and_z0_const", B, 1'b1);
    step(2'b00, 2'b10, 2'b10, 1'b1, "and_z1");
    check("and_z1_const", B, 1'b0);

    // Pass-through of A when z is zero.
    step(2'b00, 2'b01, 2'b00, 1'b1, "pass_a1");
    check("pass_a1_const", B, 1'b1);
    step(2'b00, 2'b01, 2'b00, 1'b0, "pass_a0");
    check("pass_a0_const", B, 1'b0);

    // Hold while x and y are both zero.
    step(2'b01, 2'b00, 2'b00, 1'b0, "hold_set");
    for (int i = 0; i < 5; i++) begin
      step(2'b00, 2'b00, W'($urandom), 1'($urandom), "hold");
      check("hold_const", B, 1'b1);
    end

    // Asynchronous reset with B = 1, held low across falling edges.
    #2;
    rst_n = 1'b0;
    #1;
    exp_b = 1'b0;
    check("reset_async", B, 1'b0);
    step(2'b01, 2'b00, 2'b00, 1'b1, "reset_held");
    step(2'b11, 2'b11, 2'b11, 1'b1, "reset_held");
    check("reset_held_const", B, 1'b0);
    #2;
    rst_n = 1'b1;
    step(2'b00, 2'b00, 2'b11, 1'b1, "reset_release_hold");
    check("reset_release_hold_const", B, 1'b0);
    step(2'b00, 2'b01, 2'b00, 1'b1, "reset_release_load");
    check("reset_release_load_const", B, 1'b1);

    // Full sweep of {x, y, z, A}.
    for (int i = 0; i < 128; i++) begin
      logic [6:0] v;
      v = 7'(i);
      step(v[6:5], v[4:3], v[2:1], v[0], "sweep");
    end

    // Randomized traffic with occasional asynchronous reset pulses.
    for (int i = 0; i < 300; i++) begin
      step(W'($urandom), W'($urandom), W'($urandom), 1'($urandom), "random");
      if ($urandom_range(0, 39) == 0) mid_reset("random_reset");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_negedge_and_or_reg

// File: doc/negedge_and_or_reg.md
# negedge_and_or_reg

Single-bit registered selector: on each falling clock edge it evaluates two OR/AND conditions over three 2-bit operand buses and loads a one-bit AND or OR result into output `B`, holding it otherwise. It is a small control-path register used as a logic-synthesis and netlist-import regression block. Verification compares `B` each cycle against a golden model with a combinational equality checker (`assert_comb`).

## Interface
Parameters:
- `W`, default 2: width of the `x`, `y` and `z` operand buses. The block must be correct for `W >= 1`; regression uses 2.

Ports:
- `clk`  in  1: clock; all state updates on the **falling** edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `x`  in  W: operand bus X.
- `y`  in  W: operand bus Y.
- `z`  in  W: operand bus Z.
- `A`  in  1: data bit.
- `B`  out  1: registered result.

## Operation
- Reductions, all combinational:
  - `xa = |x`, `ya = |y`, `za = |z`.
  - `c1 = xa | (ya & za)`.
  - `c2 = xa | (ya & ~za)`.
- Candidate values:
  - `v1 = A & z[0]`, the LSB of `z`.
  - `v2 = A | x[0]`, the LSB of `x`.
  - Wider bits do not feed the data path; they only enter through the reductions.
- Next-state, with priority:
  - If `c2`: load `v2`. This overrides `c1`.
  - Else if `c1`: load `v1`.
  - Else: hold.
- Resulting truth summary:
  - `x != 0` → `B <= A | x[0]`.
  - `x == 0`, `y != 0`, `z != 0` → `B <= A & z[0]`.
  - `x == 0`, `y != 0`, `z == 0` → `B <= A`.
  - `x == 0`, `y == 0` → hold.
- Reset value: `B = 0`.

## Timing
- `B` is a flop clocked on the negedge of `clk`, with latency 1 falling edge.
- Inputs are sampled at the falling edge. `B` changes only just after a falling edge or on reset assertion.
- Rising edges have no effect.
- `rst_n` low forces `B = 0` immediately, independent of `clk`, and holds it while low.
- Reset release follows the normal rules: the first falling edge with `rst_n = 1` evaluates normally.
- If `rst_n` rises coincident with a falling edge, that edge is ignored and `B` stays 0.
- No handshake and no X-propagation requirements beyond standard RTL.

## Structure
- No shared package required. Optionally keep a constant `B_RST = 1'b0` in the project-wide package.
- One combinational sub-module is natural: `and_or_next` (inputs `x`, `y`, `z`, `A`, current `B`; output next `B`). The top module wraps it with the negedge async-reset flop.
- The checker `assert_comb` is verification-only and separate. It is combinational:
  - Flags an error when its inputs `A != B`.
  - Must ignore X on either input until after reset is released.

## Test plan
- Reset: assert `rst_n = 0` mid-cycle with `B = 1` → `B = 0` immediately, and it stays 0 across falling edges while low.
- X-dominant: `x = 2'b01`, `y = 0`, `z = 2'b11`, `A = 0`, then a falling edge → `B = 1`. Then `x = 2'b10`, `A = 0` → `B = 0`.
- AND path: `x = 0`, `y = 2'b10`, `z = 2'b01`, `A = 1` → `B = 1`. Then `z = 2'b10` → `B = 0`, because `z[0] = 0`.
- Pass-through: `x = 0`, `y = 2'b01`, `z = 0` → `B` follows `A` (`A = 1` gives 1, `A = 0` gives 0).
- Hold: `B = 1`, then `x = 0`, `y = 0`, with any `z` and `A`, for 5 falling edges → `B` stays 1.
- Exhaustive: drive the 8-bit vector `{clk, x, y, z, A}` as a counter stepping every 5 time units for 10000 steps. Compare `B` against the golden model with `assert_comb` → zero mismatches.
